calc_frame_ctrl: RTL
====================

# calc_frame_ctrl

Parametrised frame sequencer for the UART calculator datapath. It sits between the word receiver (`word_rx`), the `alu` and the word transmitter (`word_tx`). It collects an A/B/OP word frame, registers the operands, captures the ALU result, and transmits the low result word, or low then high in wide mode. It adds an inter-word timeout that resynchronises a broken frame, and it flags overruns.

## Interface
- `WORD_W`, 32, width of operand, result and transfer words
- `OP_W`, 4, width of the ALU op select; taken from `word_in[OP_W-1:0]`
- `TIMEOUT_CYCLES`, 65536, clock cycles allowed between consecutive words of one frame
- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `word_in`  in  WORD_W  word from receiver
- `word_valid`  in  1  one-cycle strobe; `word_in` valid
- `operand_a`, `operand_b`  out  WORD_W  registered ALU operands
- `op_select`  out  OP_W  registered ALU op
- `result_lo`, `result_hi`  in  WORD_W  combinational ALU results
- `tx_word`  out  WORD_W  word to transmitter, held stable until `tx_done`
- `tx_send`  out  1  one-cycle send pulse
- `tx_done`  in  1  one-cycle pulse; transmitter finished the word
- `busy`  out  1  high in EXEC, SEND_*, WAIT_*
- `overrun`  out  1  sticky; a word arrived while busy
- `timeout_err`  out  1  one-cycle pulse; frame abandoned
- `state`  out  3  encoded FSM state, for debug

## Operation
- FSM states: IDLE (wait A), GET_B, GET_OP, EXEC, SEND_LO, WAIT_LO, SEND_HI, WAIT_HI.
- IDLE + `word_valid`: `operand_a` <= `word_in`, then GET_B.
- GET_B + `word_valid`: `operand_b` <= `word_in`, then GET_OP.
- GET_OP + `word_valid`:
  - `op_select` <= `word_in[OP_W-1:0]`.
  - Wide flag <= `word_in[OP_W]`.
  - Next state EXEC.
- EXEC:
  - Register `result_lo` and `result_hi` into internal holding registers.
  - Next state SEND_LO.
- SEND_LO:
  - `tx_word` <= held lo.
  - `tx_send` = 1 for this cycle only.
  - Next state WAIT_LO.
- WAIT_LO + `tx_done`: go to SEND_HI if the wide flag is set, else IDLE.
- SEND_HI / WAIT_HI: same as SEND_LO / WAIT_LO using held hi; WAIT_HI + `tx_done` goes to IDLE.
- `word_valid` while `busy`: the word is dropped and `overrun` is set. `overrun` clears only on reset.
- `tx_done` outside WAIT_* is ignored.
- Operands and op hold their value until overwritten by the next frame.

## Timing
- Reset values:
  - State IDLE; `operand_a`, `operand_b`, `op_select`, `tx_word` all 0.
  - `tx_send`, `busy`, `overrun`, `timeout_err` all 0; `state` = 0 (IDLE).
- Latency:
  - OP word accepted on edge t: EXEC in cycle t+1, `tx_send` high in cycle t+2.
  - `tx_done` on edge u: SEND_HI (`tx_send`) high in cycle u+1.
- The ALU is purely combinational, so results are valid one cycle after the operands are registered. EXEC samples them at that point.
- Timeout, when compiled in:
  - The counter clears on every accepted word and counts only in GET_B and GET_OP.
  - When the count reaches `TIMEOUT_CYCLES-1`, the FSM goes to IDLE and `timeout_err` pulses for 1 cycle.
  - Any partial operands already registered are kept.
- Simultaneous `word_valid` and timeout expiry: the word wins. It is accepted, the counter clears and there is no error.
- `rst_n` asserted mid-frame or mid-send: immediate return to reset values. A `tx_send` pulse already issued is not revoked.

## Configuration
- `CALC_TIMEOUT_EN` defined:
  - The timeout counter (width `$clog2(TIMEOUT_CYCLES)`) and abandon logic are present.
- Not defined:
  - No counter; `timeout_err` is tied to 0.
  - A partial frame waits indefinitely, as in the first-generation calculator.

## Structure
- Package `calc_pkg` holds:
  - The `calc_state_t` enum (3-bit encoding, IDLE = 0).
  - The default `WORD_W` and `OP_W` localparams.
  - The wide-mode flag position (bit `OP_W` of the OP word).
- Sub-module `calc_timeout`: counter with `clear`, `enable`, `expired`.
  - Instantiated only under `CALC_TIMEOUT_EN`.

## Test plan
- Narrow frame:
  - A = 0x00000005, B = 0x00000007, OP = 0x00000000; bench ALU drives lo = 0x0000000C.
  - Expect exactly one `tx_send`, two cycles after the OP strobe, with `tx_word` = 0x0000000C; back to IDLE after `tx_done`.
- Wide frame:
  - OP = 0x00000013 (flag bit 4 set); lo = 0x89ABCDEF, hi = 0x01234567.
  - Expect two sends in order, lo then hi; SEND_HI one cycle after the first `tx_done`.
- Overrun:
  - Strobe an extra word during WAIT_LO.
  - Expect the word to be ignored, `overrun` = 1 and held, and the next frame to still process correctly.
- Timeout (macro on, `TIMEOUT_CYCLES` = 16):
  - Send A, then nothing for 20 cycles.
  - Expect `timeout_err` pulse at cycle 15 after A and state IDLE. The next three words then form a valid frame.
- Timeout boundary:
  - Strobe B exactly on the expiry cycle.
  - Expect no `timeout_err` and state GET_OP.
- Reset mid-send:
  - Drop `rst_n` in WAIT_LO.
  - Expect all outputs at reset values asynchronously; a fresh frame after release works.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and defaults for the UART calculator frame sequencer.
package calc_pkg;

    localparam int CALC_WORD_W   = 32;
    localparam int CALC_OP_W     = 4;
    // The wide-mode flag sits just above the op field in the OP word.
    localparam int CALC_WIDE_BIT = CALC_OP_W;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_B   = 3'd1,
        ST_GET_OP  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_SEND_HI = 3'd6,
        ST_WAIT_HI = 3'd7
    } calc_state_t;

    function automatic logic calc_is_busy(input calc_state_t s);
        return (s == ST_EXEC)    || (s == ST_SEND_LO) || (s == ST_WAIT_LO) ||
               (s == ST_SEND_HI) || (s == ST_WAIT_HI);
    endfunction

endpackage

// File: rtl/calc_timeout.sv
// Inter-word timeout counter: clears on each accepted word, counts while a frame is open.
module calc_timeout #(
    parameter int unsigned CYCLES = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count; saturates at LAST so the expiry stays visible until the FSM reacts.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/calc_frame_ctrl.sv
// A/B/OP frame sequencer between word_rx, alu and word_tx.
// Optional inter-word timeout compiled in with CALC_TIMEOUT_EN.
module calc_frame_ctrl
    import calc_pkg::*;
#(
    parameter int          WORD_W         = CALC_WORD_W,
    parameter int          OP_W           = CALC_OP_W,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic [WORD_W-1:0] operand_a,
    output logic [WORD_W-1:0] operand_b,
    output logic [OP_W-1:0]   op_select,
    input  logic [WORD_W-1:0] result_lo,
    input  logic [WORD_W-1:0] result_hi,
    output logic [WORD_W-1:0] tx_word,
    output logic              tx_send,
    input  logic              tx_done,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err,
    output logic [2:0]        state
);

    localparam int WIDE_POS = OP_W + (CALC_WIDE_BIT - CALC_OP_W);

    calc_state_t       state_q, state_d;
    logic [WORD_W-1:0] opa_q, opa_d;
    logic [WORD_W-1:0] opb_q, opb_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              wide_q, wide_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] txw_q, txw_d;
    logic              tx_send_q, busy_q, overrun_q;
    logic              word_accept_s, collecting_s, expired_s, timeout_s;

    assign collecting_s = (state_q == ST_GET_B) || (state_q == ST_GET_OP);

`ifdef CALC_TIMEOUT_EN
    calc_timeout #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (word_accept_s),
        .enable_i (collecting_s),
        .expired_o(expired_s)
    );
`else
    localparam bit TIMEOUT_USED = (TIMEOUT_CYCLES > 0);
    assign expired_s = 1'b0 & TIMEOUT_USED;
`endif

    // A word arriving on the expiry cycle wins over the timeout.
    assign timeout_s = collecting_s && expired_s && !word_valid;

    // Frame sequencing and data-path next state.
    always_comb begin
        state_d       = state_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        op_d          = op_q;
        wide_d        = wide_q;
        hi_d          = hi_q;
        txw_d         = txw_q;
        word_accept_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (word_valid) begin
                    opa_d         = word_in;
                    word_accept_s = 1'b1;
                    state_d       = ST_GET_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_B: begin
                if (word_valid) begin
                    opb_d         = word_in;
                    word_accept_s = 1'b1;
                    state_d       = ST_GET_OP;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_B;
                end
            end
            ST_GET_OP: begin
                if (word_valid) begin
                    op_d          = word_in[OP_W-1:0];
                    wide_d        = word_in[WIDE_POS];
                    word_accept_s = 1'b1;
                    state_d       = ST_EXEC;
                end else if (timeout_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GET_OP;
                end
            end
            ST_EXEC: begin
                // tx_word doubles as the low-result holding register.
                hi_d    = result_hi;
                txw_d   = result_lo;
                state_d = ST_SEND_LO;
            end
            ST_SEND_LO: state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (tx_done && wide_q) begin
                    txw_d   = hi_q;
                    state_d = ST_SEND_HI;
                end else if (tx_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_SEND_HI: state_d = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            op_q      <= '0;
            wide_q    <= 1'b0;
            hi_q      <= '0;
            txw_q     <= '0;
            tx_send_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            op_q      <= op_d;
            wide_q    <= wide_d;
            hi_q      <= hi_d;
            txw_q     <= txw_d;
            tx_send_q <= (state_d == ST_SEND_LO) || (state_d == ST_SEND_HI);
            busy_q    <= calc_is_busy(state_d);
            overrun_q <= overrun_q | (word_valid & busy_q);
        end
    end

    assign operand_a   = opa_q;
    assign operand_b   = opb_q;
    assign op_select   = op_q;
    assign tx_word     = txw_q;
    assign tx_send     = tx_send_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_s;
    assign state       = state_q;

endmodule
